csr_trap_unit: RTL and testbench

Machine-mode CSR file and trap sequencer for the pipelined core, sitting beside the Execute stage. It executes all six Zicsr ops (register and immediate forms) on a small M-mode register set, takes ecall, illegal-CSR, external and timer-interrupt traps, and executes mret. A three-state FSM drives pipeline flush and PC redirect, then masks interrupts while the pipeline refills.

---
 rtl/csr_trap_unit.sv | 130 +++++++++++++
 tb/tb_csr_trap_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file and trap/mret sequencer driving pipeline flush and PC redirect
// Ports: i_clk, i_rst (async, active-high); E-stage inputs i_valid_e, i_stall, i_csr_e, i_f3_e,
//   i_csr_addr_e, i_rs1_idx_e, i_rs1_data_e, i_ecall_e, i_mret_e, i_pc_e; level irqs i_irq_ext,
//   i_irq_timer; o_rd_data_e (old CSR value), o_flush/o_redirect/o_redirect_pc (one FLUSH cycle).
// Option: CSR_VECTORED_MTVEC_EN makes mtvec[1:0] writable and enables vectored interrupt targets.
`ifndef XLEN_64b
`define XLEN_64b 2
`endif
module csr_trap_unit #(
  parameter int XLEN = `XLEN_64b,
  localparam int W = 1 << (XLEN + 4),
  parameter logic [W-1:0] MTVEC_RESET = '0,
  parameter int REFILL_CYCLES = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid_e,
  input  logic         i_stall,
  input  logic         i_csr_e,
  input  logic [2:0]   i_f3_e,
  input  logic [11:0]  i_csr_addr_e,
  input  logic [4:0]   i_rs1_idx_e,
  input  logic [W-1:0] i_rs1_data_e,
  input  logic         i_ecall_e,
  input  logic         i_mret_e,
  input  logic [W-1:0] i_pc_e,
  input  logic         i_irq_ext,
  input  logic         i_irq_timer,
  output logic [W-1:0] o_rd_data_e,
  output logic         o_redirect,
  output logic [W-1:0] o_redirect_pc,
  output logic         o_flush
);
  typedef enum logic [1:0] {IDLE, FLUSH, REFILL} state_t;
  state_t state_q;
  logic [3:0] cnt_q, code;
  logic mie_q, mpie_q, meie_q, mtie_q;
  logic [W-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, rpc_q;
  logic [W-1:0] old, op, nv, base, tgt;
  logic legal, csr_op, commit, irq, ill, trap, mret, go, wr;
  always_comb begin
    legal = 1'b1;
    old = '0;
    case (i_csr_addr_e)
      12'h300: old = W'({2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0});
      12'h304: old = W'({meie_q, 3'b0, mtie_q, 7'b0});
      12'h305: old = mtvec_q;
      12'h340: old = mscratch_q;
      12'h341: old = mepc_q;
      12'h342: old = mcause_q;
      12'h344: old = W'({i_irq_ext, 3'b0, i_irq_timer, 7'b0});
      default: legal = 1'b0;
    endcase
  end
  assign op = i_f3_e[2] ? W'(i_rs1_idx_e) : i_rs1_data_e;
  assign nv = (i_f3_e[1:0] == 2'b01) ? op : (i_f3_e[1:0] == 2'b10) ? (old | op) : (old & ~op);
  assign csr_op = i_csr_e & (i_f3_e[1:0] != 2'b00);
  assign commit = i_valid_e & ~i_stall & (state_q != FLUSH);
  // interrupts are only sampled in IDLE, masking them while the pipeline refills
  assign irq = commit & (state_q == IDLE) & mie_q & ((meie_q & i_irq_ext) | (mtie_q & i_irq_timer));
  assign ill = commit & csr_op & ~legal;
  assign trap = irq | ill | (commit & i_ecall_e);
  assign mret = commit & i_mret_e & ~trap;
  assign go = trap | mret;
  assign wr = commit & csr_op & legal & ~trap & ~(i_f3_e[1] & (i_rs1_idx_e == 5'd0));
  assign code = (irq & meie_q & i_irq_ext) ? 4'd11 : irq ? 4'd7 : ill ? 4'd2 : 4'd11;
  assign base = {mtvec_q[W-1:2], 2'b00};
`ifdef CSR_VECTORED_MTVEC_EN
  assign tgt = mret ? mepc_q : (irq && mtvec_q[1:0] == 2'b01) ? base + W'({code, 2'b00}) : base;
`else
  assign tgt = mret ? mepc_q : base;
`endif
  assign o_rd_data_e = old;
  assign o_flush = state_q == FLUSH;
  assign o_redirect = state_q == FLUSH;
  assign o_redirect_pc = rpc_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      mie_q <= 1'b0;
      mpie_q <= 1'b0;
      meie_q <= 1'b0;
      mtie_q <= 1'b0;
`ifdef CSR_VECTORED_MTVEC_EN
      mtvec_q <= MTVEC_RESET;
`else
      mtvec_q <= {MTVEC_RESET[W-1:2], 2'b00};
`endif
      mscratch_q <= '0;
      mepc_q <= '0;
      mcause_q <= '0;
      rpc_q <= '0;
    end else begin
      state_q <= go ? FLUSH : (state_q == FLUSH) ? REFILL : (state_q == REFILL && cnt_q == 4'd1) ? IDLE : state_q;
      cnt_q <= (state_q == FLUSH) ? 4'(REFILL_CYCLES) : (state_q == REFILL) ? cnt_q - 4'd1 : cnt_q;
      rpc_q <= go ? tgt : '0;
      if (wr)
        case (i_csr_addr_e)
          12'h300: begin
            mie_q <= nv[3];
            mpie_q <= nv[7];
          end
          12'h304: begin
            meie_q <= nv[11];
            mtie_q <= nv[7];
          end
`ifdef CSR_VECTORED_MTVEC_EN
          12'h305: mtvec_q <= nv;
`else
          12'h305: mtvec_q <= {nv[W-1:2], 2'b00};
`endif
          12'h340: mscratch_q <= nv;
          12'h341: mepc_q <= nv & ~W'(3);
          12'h342: mcause_q <= nv;
          default: ;
        endcase
      if (trap) begin
        mepc_q <= i_pc_e & ~W'(3);
        mcause_q <= {irq, {(W-5){1'b0}}, code};
        mpie_q <= mie_q;
        mie_q <= 1'b0;
      end
      if (mret) begin
        mie_q <= mpie_q;
        mpie_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: table-driven vectors, next-cycle flush/redirect expectations held in a scoreboard queue
module tb_csr_trap_unit;
`ifdef CSR_VECTORED_MTVEC_EN
  localparam logic [63:0] MTV = 64'h201, VPC = 64'h22C;
`else
  localparam logic [63:0] MTV = 64'h200, VPC = 64'h200;
`endif
  localparam logic [2:0] RW = 3'b001, RS = 3'b010, RSI = 3'b110, RCI = 3'b111;
  logic clk = 1'b0, rst = 1'b1;
  logic valid, stall, csr, ecall, mret, irq_ext, irq_tim;
  logic [2:0] f3;
  logic [11:0] addr;
  logic [4:0] idx;
  logic [63:0] rs1, pc, rd_data, rpc;
  logic redirect, flush;
  always #5 clk = ~clk;
  csr_trap_unit dut (
    .i_clk(clk), .i_rst(rst), .i_valid_e(valid), .i_stall(stall), .i_csr_e(csr), .i_f3_e(f3),
    .i_csr_addr_e(addr), .i_rs1_idx_e(idx), .i_rs1_data_e(rs1), .i_ecall_e(ecall), .i_mret_e(mret),
    .i_pc_e(pc), .i_irq_ext(irq_ext), .i_irq_timer(irq_tim), .o_rd_data_e(rd_data),
    .o_redirect(redirect), .o_redirect_pc(rpc), .o_flush(flush)
  );
  typedef struct {
    logic v, st, csr;
    logic [2:0] f3;
    logic [11:0] a;
    logic [4:0] idx;
    logic [63:0] d;
    logic ec, mr, ext, tim;
    logic [63:0] pc;
    logic chk;
    logic [63:0] rd;
    logic fl;
    logic [63:0] rpc;
  } vec_t;
  typedef struct {
    int n;
    logic fl;
    logic [63:0] rpc;
  } exp_t;
  vec_t vq[$];
  exp_t sb[$];
  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic add(input logic v, st, c, input logic [2:0] f, input logic [11:0] a, input logic [4:0] ix,
                     input logic [63:0] d, input logic ec, mr, ext, tim, input logic [63:0] p,
                     input logic ck, input logic [63:0] r, input logic fl, input logic [63:0] rp);
    vec_t x;
    x = '{v, st, c, f, a, ix, d, ec, mr, ext, tim, p, ck, r, fl, rp};
    vq.push_back(x);
  endtask
  task automatic cop(input logic [2:0] f, input logic [11:0] a, input logic [4:0] ix, input logic [63:0] d,
                     input logic [63:0] r, input logic ext, tim);
    add(1, 0, 1, f, a, ix, d, 0, 0, ext, tim, 64'h0, 1, r, 0, 64'h0);
  endtask
  task automatic ev(input logic v, st, ec, mr, ext, tim, input logic [63:0] p, input logic fl,
                    input logic [63:0] rp);
    add(v, st, 0, 3'b0, 12'h0, 5'd0, 64'h0, ec, mr, ext, tim, p, 0, 64'h0, fl, rp);
  endtask
  task automatic drive(input vec_t x);
    valid = x.v; stall = x.st; csr = x.csr; f3 = x.f3; addr = x.a; idx = x.idx; rs1 = x.d;
    ecall = x.ec; mret = x.mr; irq_ext = x.ext; irq_tim = x.tim; pc = x.pc;
  endtask
  task automatic pop();
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk($sformatf("redir%0d", e.n), {flush, redirect, rpc}, {e.fl, e.fl, e.rpc});
    end
  endtask
  initial begin
    vec_t z;
    z = '{0, 0, 0, 3'b0, 12'h0, 5'd0, 64'h0, 0, 0, 0, 0, 64'h0, 0, 64'h0, 0, 64'h0};
    drive(z);
    repeat (2) @(negedge clk);
    chk("reset_out", {flush, redirect, rpc}, 66'd0);
    rst = 1'b0;
    cop(RS, 12'h300, 0, 64'h88, 64'h1800, 0, 0);
    cop(RS, 12'h300, 0, 64'h0, 64'h1800, 0, 0);
    cop(RW, 12'h340, 1, 64'hA5, 64'h0, 0, 0);
    cop(RS, 12'h340, 1, 64'h5A, 64'hA5, 0, 0);
    cop(RS, 12'h340, 0, 64'h0, 64'hFF, 0, 0);
    cop(RCI, 12'h340, 5'h0F, 64'h0, 64'hFF, 0, 0);
    cop(RS, 12'h340, 0, 64'h0, 64'hF0, 0, 0);
    cop(RW, 12'h305, 1, 64'h100, 64'h0, 0, 0);
    cop(RSI, 12'h300, 8, 64'h0, 64'h1800, 0, 0);
    cop(RS, 12'h300, 0, 64'h0, 64'h1808, 0, 0);
    ev(1, 0, 1, 0, 0, 0, 64'h40, 1, 64'h100);
    ev(1, 0, 1, 0, 0, 0, 64'h99, 0, 64'h0);
    cop(RS, 12'h342, 0, 64'h0, 64'd11, 0, 0);
    cop(RS, 12'h341, 0, 64'h0, 64'h40, 0, 0);
    cop(RS, 12'h300, 0, 64'h0, 64'h1880, 0, 0);
    add(1, 0, 1, RW, 12'h7C0, 1, 64'h123, 0, 0, 0, 0, 64'h44, 0, 64'h0, 1, 64'h100);
    ev(0, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0);
    cop(RS, 12'h342, 0, 64'h0, 64'd2, 0, 0);
    cop(RS, 12'h341, 0, 64'h0, 64'h44, 0, 0);
    cop(RS, 12'h340, 0, 64'h0, 64'hF0, 0, 0);
    cop(RS, 12'h304, 1, 64'h880, 64'h0, 0, 0);
    cop(RS, 12'h304, 0, 64'h0, 64'h880, 0, 0);
    cop(RW, 12'h344, 1, 64'hFFF, 64'h80, 0, 1);
    cop(RSI, 12'h300, 8, 64'h0, 64'h1800, 0, 0);
    ev(1, 0, 1, 0, 0, 1, 64'h80, 1, 64'h100);
    ev(0, 0, 0, 0, 0, 1, 64'h0, 0, 64'h0);
    cop(RS, 12'h342, 0, 64'h0, 64'h8000_0000_0000_0007, 0, 1);
    ev(1, 0, 0, 1, 0, 1, 64'h84, 1, 64'h80);
    ev(0, 0, 0, 0, 0, 1, 64'h0, 0, 64'h0);
    cop(RS, 12'h300, 0, 64'h0, 64'h1888, 0, 1);
    ev(1, 0, 0, 0, 0, 1, 64'h90, 0, 64'h0);
    ev(1, 0, 0, 0, 0, 1, 64'h94, 0, 64'h0);
    ev(1, 0, 0, 0, 0, 1, 64'h98, 1, 64'h100);
    ev(0, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0);
    cop(RS, 12'h341, 0, 64'h0, 64'h98, 0, 0);
    cop(RW, 12'h305, 1, 64'h201, 64'h100, 0, 0);
    cop(RS, 12'h305, 0, 64'h0, MTV, 0, 0);
    cop(RSI, 12'h300, 8, 64'h0, 64'h1880, 0, 0);
    ev(1, 0, 0, 0, 1, 0, 64'hA0, 1, VPC);
    ev(0, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0);
    cop(RS, 12'h342, 0, 64'h0, 64'h8000_0000_0000_000B, 0, 0);
    ev(0, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0);
    ev(0, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0);
    ev(1, 1, 1, 0, 0, 0, 64'hC0, 0, 64'h0);
    cop(RS, 12'h341, 0, 64'h0, 64'hA0, 0, 0);
    for (int i = 0; i < vq.size(); i++) begin
      exp_t e;
      if (i != 0) @(negedge clk);
      pop();
      drive(vq[i]);
      e = '{i, vq[i].fl, vq[i].rpc};
      sb.push_back(e);
      #1;
      if (vq[i].chk) chk($sformatf("rd%0d", i), {2'b0, rd_data}, {2'b0, vq[i].rd});
    end
    @(negedge clk);
    pop();
    z.v = 1; z.ec = 1; z.pc = 64'hB0;
    drive(z);
    @(posedge clk);
    #1;
    chk("flush_pre_rst", {flush, redirect, rpc}, {1'b1, 1'b1, 64'h200});
    z.v = 0; z.ec = 0;
    drive(z);
    rst = 1'b1;
    #1;
    chk("rst_mid_flush", {flush, redirect, rpc}, 66'd0);
    @(negedge clk);
    rst = 1'b0;
    z = '{1, 0, 1, RS, 12'h300, 5'd0, 64'h0, 0, 0, 0, 0, 64'h0, 0, 64'h0, 0, 64'h0};
    drive(z);
    #1;
    chk("mstatus_after_rst", {2'b0, rd_data}, {2'b0, 64'h1800});
    @(negedge clk);
    chk("no_redirect_after_rst", {flush, redirect, rpc}, 66'd0);
    z.a = 12'h305;
    drive(z);
    #1;
    chk("mtvec_after_rst", {2'b0, rd_data}, 66'd0);
    @(negedge clk);
    z.a = 12'h340;
    drive(z);
    #1;
    chk("mscratch_after_rst", {2'b0, rd_data}, 66'd0);
    @(negedge clk);
    z.v = 0;
    drive(z);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
